// File: rtl/tx_fifo_sched.sv
// TX scheduler: pops one byte at a time from the TX FIFO and hands it to the
// UART transmitter, with an idle gap between frames and a busy-rise timeout.
module tx_fifo_sched #(
  parameter int DATA_WD  = 8,
  parameter int GAP_CYC  = 2,
  parameter int BUSY_TMO = 64,
  parameter int CNT_WD   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TX_EN,
  input  logic               FIFO_EMPTY,
  input  logic [DATA_WD-1:0] FIFO_RD_DATA,
  output logic               RD_INC,
  input  logic               TX_BUSY,
  output logic [DATA_WD-1:0] TX_DATA,
  output logic               TX_DATA_VLD,
  input  logic               ERR_CLR,
  output logic               TMO_ERR,
  output logic               ACTIVE,
  output logic [CNT_WD-1:0]  SENT_CNT
);

  // state     | meaning
  // IDLE      | waiting for TX_EN and a non-empty FIFO
  // LAUNCH    | byte presented, waiting (timed) for TX_BUSY to rise
  // WAIT_DONE | UART shifting the byte, waiting for TX_BUSY to fall
  // GAP       | enforced idle time before the next pop

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int TMO_WD = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam int GAP_WD = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TMO_WD-1:0] TMO_LOAD = TMO_WD'(BUSY_TMO - 1);
  localparam logic [GAP_WD-1:0] GAP_LOAD = GAP_WD'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam bit NO_GAP = (GAP_CYC == 0);

  state_t              state_q, state_d;
  logic [TMO_WD-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GAP_WD-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DATA_WD-1:0]  tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic                rd_inc_q, rd_inc_d;
  logic                tmo_err_q, tmo_err_d;
  logic                active_q, active_d;
  logic [CNT_WD-1:0]   sent_cnt_q, sent_cnt_d;

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    rd_inc_d   = 1'b0;
    tmo_err_d  = tmo_err_q;
    sent_cnt_d = sent_cnt_q;

    // Clear first so a timeout in the same cycle overrides it.
    if (ERR_CLR) tmo_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (TX_EN && !FIFO_EMPTY) begin
          state_d   = LAUNCH;
          tx_data_d = FIFO_RD_DATA;
          tx_vld_d  = 1'b1;
          rd_inc_d  = 1'b1;
          tmo_cnt_d = TMO_LOAD;
        end
      end
      LAUNCH: begin
        if (TX_BUSY) begin
          state_d  = WAIT_DONE;
          tx_vld_d = 1'b0;
        end else if (tmo_cnt_q == '0) begin
          tx_vld_d  = 1'b0;
          tmo_err_d = 1'b1;
          if (NO_GAP) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          sent_cnt_d = sent_cnt_q + 1'b1;
          if (NO_GAP) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: begin
        state_d  = IDLE;
        tx_vld_d = 1'b0;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rd_inc_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
      active_q   <= 1'b0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rd_inc_q   <= rd_inc_d;
      tmo_err_q  <= tmo_err_d;
      active_q   <= active_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign RD_INC      = rd_inc_q;
  assign TX_DATA     = tx_data_q;
  assign TX_DATA_VLD = tx_vld_q;
  assign TMO_ERR     = tmo_err_q;
  assign ACTIVE      = active_q;
  assign SENT_CNT    = sent_cnt_q;

endmodule

// File: tb/tb_tx_fifo_sched.sv
// Directed bench for tx_fifo_sched: instance a uses default parameters,
// instance b uses CNT_WD=4 / GAP_CYC=0 for wrap and back-to-back checks.
module tb_tx_fifo_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx_en_a = 1'b0, tx_busy_a = 1'b0, err_clr_a = 1'b0;
  logic       fifo_empty_a, rd_inc_a, tx_data_vld_a, tmo_err_a, active_a;
  logic [7:0] fifo_rd_data_a, tx_data_a;
  logic [15:0] sent_cnt_a;

  logic       tx_en_b = 1'b0, tx_busy_b = 1'b0, err_clr_b = 1'b0;
  logic       fifo_empty_b, rd_inc_b, tx_data_vld_b, tmo_err_b, active_b;
  logic [7:0] fifo_rd_data_b, tx_data_b;
  logic [3:0] sent_cnt_b;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // FIFO models: tasks write entries, the negedge process consumes on RD_INC.
  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:31];
  logic [7:0] log_a [0:31];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  logic bad_pop_a = 1'b0, bad_pop_b = 1'b0;

  assign fifo_empty_a   = (wr_a == rd_a);
  assign fifo_rd_data_a = mem_a[rd_a[4:0]];
  assign fifo_empty_b   = (wr_b == rd_b);
  assign fifo_rd_data_b = mem_b[rd_b[4:0]];

  always @(negedge clk) begin
    if (rd_inc_a) begin
      if (wr_a == rd_a) bad_pop_a <= 1'b1;
      log_a[rd_a[4:0]] <= tx_data_a;
      rd_a <= rd_a + 1;
    end
    if (rd_inc_b) begin
      if (wr_b == rd_b) bad_pop_b <= 1'b1;
      rd_b <= rd_b + 1;
    end
  end

  tx_fifo_sched dut_a (
    .CLK(clk), .RST(rst), .TX_EN(tx_en_a), .FIFO_EMPTY(fifo_empty_a),
    .FIFO_RD_DATA(fifo_rd_data_a), .RD_INC(rd_inc_a), .TX_BUSY(tx_busy_a),
    .TX_DATA(tx_data_a), .TX_DATA_VLD(tx_data_vld_a), .ERR_CLR(err_clr_a),
    .TMO_ERR(tmo_err_a), .ACTIVE(active_a), .SENT_CNT(sent_cnt_a)
  );

  tx_fifo_sched #(.DATA_WD(8), .GAP_CYC(0), .BUSY_TMO(8), .CNT_WD(4)) dut_b (
    .CLK(clk), .RST(rst), .TX_EN(tx_en_b), .FIFO_EMPTY(fifo_empty_b),
    .FIFO_RD_DATA(fifo_rd_data_b), .RD_INC(rd_inc_b), .TX_BUSY(tx_busy_b),
    .TX_DATA(tx_data_b), .TX_DATA_VLD(tx_data_vld_b), .ERR_CLR(err_clr_b),
    .TMO_ERR(tmo_err_b), .ACTIVE(active_b), .SENT_CNT(sent_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] v);
    mem_a[wr_a[4:0]] = v;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [7:0] v);
    mem_b[wr_b[4:0]] = v;
    wr_b = wr_b + 1;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++; if (rd_inc_a !== 1'b0) begin mis_cnt++; $display("FAIL reset_rd_inc: got %b exp 0", rd_inc_a); end
    cmp_cnt++; if (tx_data_a !== 8'h00) begin mis_cnt++; $display("FAIL reset_tx_data: got %h exp 00", tx_data_a); end
    cmp_cnt++; if (tx_data_vld_a !== 1'b0) begin mis_cnt++; $display("FAIL reset_vld: got %b exp 0", tx_data_vld_a); end
    cmp_cnt++; if (tmo_err_a !== 1'b0) begin mis_cnt++; $display("FAIL reset_tmo_err: got %b exp 0", tmo_err_a); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL reset_active: got %b exp 0", active_a); end
    cmp_cnt++; if (sent_cnt_a !== 16'd0) begin mis_cnt++; $display("FAIL reset_sent_cnt: got %0d exp 0", sent_cnt_a); end
    cmp_cnt++; if (sent_cnt_b !== 4'd0) begin mis_cnt++; $display("FAIL reset_sent_cnt_b: got %0d exp 0", sent_cnt_b); end
  endtask

  task automatic test_single_byte();
    int p0;
    do_reset();
    p0 = rd_a;
    push_a(8'hA5);
    tx_en_a = 1'b1;
    tick();
    cmp_cnt++; if (rd_inc_a !== 1'b1) begin mis_cnt++; $display("FAIL single_rd_inc: got %b exp 1", rd_inc_a); end
    cmp_cnt++; if (tx_data_vld_a !== 1'b1) begin mis_cnt++; $display("FAIL single_vld: got %b exp 1", tx_data_vld_a); end
    cmp_cnt++; if (tx_data_a !== 8'hA5) begin mis_cnt++; $display("FAIL single_data: got %h exp a5", tx_data_a); end
    cmp_cnt++; if (active_a !== 1'b1) begin mis_cnt++; $display("FAIL single_active: got %b exp 1", active_a); end
    tick();
    cmp_cnt++; if (rd_inc_a !== 1'b0) begin mis_cnt++; $display("FAIL single_rd_inc_pulse: got %b exp 0", rd_inc_a); end
    tick();
    cmp_cnt++; if (tx_data_vld_a !== 1'b1) begin mis_cnt++; $display("FAIL single_vld_hold: got %b exp 1", tx_data_vld_a); end
    tx_busy_a = 1'b1;
    tick();
    cmp_cnt++; if (tx_data_vld_a !== 1'b0) begin mis_cnt++; $display("FAIL single_vld_drop: got %b exp 0", tx_data_vld_a); end
    repeat (9) tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd0) begin mis_cnt++; $display("FAIL single_sent_busy: got %0d exp 0", sent_cnt_a); end
    tx_busy_a = 1'b0;
    tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd1) begin mis_cnt++; $display("FAIL single_sent: got %0d exp 1", sent_cnt_a); end
    cmp_cnt++; if (active_a !== 1'b1) begin mis_cnt++; $display("FAIL single_gap1_active: got %b exp 1", active_a); end
    tick();
    cmp_cnt++; if (active_a !== 1'b1) begin mis_cnt++; $display("FAIL single_gap2_active: got %b exp 1", active_a); end
    tick();
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL single_idle_after_gap: got %b exp 0", active_a); end
    cmp_cnt++; if (rd_a - p0 !== 1) begin mis_cnt++; $display("FAIL single_pops: got %0d exp 1", rd_a - p0); end
    tx_en_a = 1'b0;
  endtask

  task automatic test_burst();
    int p0, n;
    logic [7:0] e;
    do_reset();
    p0 = rd_a;
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    tx_en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!tx_data_vld_a && n < 20) begin tick(); n++; end
      e = 8'(8'h11 * (i + 1));
      cmp_cnt++; if (n !== ((i == 0) ? 1 : 4)) begin mis_cnt++; $display("FAIL burst_latency[%0d]: got %0d exp %0d", i, n, (i == 0) ? 1 : 4); end
      cmp_cnt++; if (tx_data_a !== e) begin mis_cnt++; $display("FAIL burst_data[%0d]: got %h exp %h", i, tx_data_a, e); end
      tx_busy_a = 1'b1;
      repeat (4) tick();
      tx_busy_a = 1'b0;
    end
    repeat (4) tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd3) begin mis_cnt++; $display("FAIL burst_sent: got %0d exp 3", sent_cnt_a); end
    cmp_cnt++; if (rd_a - p0 !== 3) begin mis_cnt++; $display("FAIL burst_pops: got %0d exp 3", rd_a - p0); end
    cmp_cnt++; if (log_a[5'(p0 + 2)] !== 8'h33) begin mis_cnt++; $display("FAIL burst_order: got %h exp 33", log_a[5'(p0 + 2)]); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL burst_idle: got %b exp 0", active_a); end
    tx_en_a = 1'b0;
  endtask

  task automatic test_timeout();
    int p0, n;
    do_reset();
    p0 = rd_a;
    tx_busy_a = 1'b0;
    push_a(8'h7E);
    tx_en_a = 1'b1;
    tick();
    cmp_cnt++; if (tx_data_a !== 8'h7E) begin mis_cnt++; $display("FAIL tmo_data: got %h exp 7e", tx_data_a); end
    n = 0;
    while (tx_data_vld_a && n < 200) begin n++; tick(); end
    cmp_cnt++; if (n !== 64) begin mis_cnt++; $display("FAIL tmo_vld_len: got %0d exp 64", n); end
    cmp_cnt++; if (tmo_err_a !== 1'b1) begin mis_cnt++; $display("FAIL tmo_err_set: got %b exp 1", tmo_err_a); end
    cmp_cnt++; if (sent_cnt_a !== 16'd0) begin mis_cnt++; $display("FAIL tmo_sent: got %0d exp 0", sent_cnt_a); end
    cmp_cnt++; if (rd_a - p0 !== 1) begin mis_cnt++; $display("FAIL tmo_pops: got %0d exp 1", rd_a - p0); end
    tx_en_a = 1'b0;
    repeat (5) tick();
    cmp_cnt++; if (tmo_err_a !== 1'b1) begin mis_cnt++; $display("FAIL tmo_err_sticky: got %b exp 1", tmo_err_a); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL tmo_idle: got %b exp 0", active_a); end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    cmp_cnt++; if (tmo_err_a !== 1'b0) begin mis_cnt++; $display("FAIL tmo_err_clr: got %b exp 0", tmo_err_a); end
  endtask

  task automatic test_enable_gating();
    int p0;
    do_reset();
    p0 = rd_a;
    tx_en_a = 1'b0;
    push_a(8'h5C);
    repeat (5) tick();
    cmp_cnt++; if (rd_a - p0 !== 0) begin mis_cnt++; $display("FAIL en_no_pop: got %0d exp 0", rd_a - p0); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL en_inactive: got %b exp 0", active_a); end
    tx_en_a = 1'b1;
    tick();
    cmp_cnt++; if (rd_inc_a !== 1'b1) begin mis_cnt++; $display("FAIL en_pop: got %b exp 1", rd_inc_a); end
    cmp_cnt++; if (tx_data_a !== 8'h5C) begin mis_cnt++; $display("FAIL en_data: got %h exp 5c", tx_data_a); end
    push_a(8'h6D);
    tx_busy_a = 1'b1;
    tick();
    tx_en_a = 1'b0;
    repeat (3) tick();
    tx_busy_a = 1'b0;
    tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd1) begin mis_cnt++; $display("FAIL en_sent: got %0d exp 1", sent_cnt_a); end
    repeat (6) tick();
    cmp_cnt++; if (rd_a - p0 !== 1) begin mis_cnt++; $display("FAIL en_blocked_pops: got %0d exp 1", rd_a - p0); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL en_blocked_active: got %b exp 0", active_a); end
    tx_en_a = 1'b1;
    tick();
    cmp_cnt++; if (rd_inc_a !== 1'b1) begin mis_cnt++; $display("FAIL en_resume_pop: got %b exp 1", rd_inc_a); end
    cmp_cnt++; if (tx_data_a !== 8'h6D) begin mis_cnt++; $display("FAIL en_resume_data: got %h exp 6d", tx_data_a); end
    tx_en_a = 1'b0;
    tx_busy_a = 1'b1;
    tick();
    tx_busy_a = 1'b0;
    repeat (4) tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd2) begin mis_cnt++; $display("FAIL en_sent2: got %0d exp 2", sent_cnt_a); end
  endtask

  task automatic test_reset_mid_launch();
    do_reset();
    push_a(8'h3C);
    tx_en_a = 1'b1;
    tick();
    cmp_cnt++; if (tx_data_vld_a !== 1'b1) begin mis_cnt++; $display("FAIL rstmid_launch: got %b exp 1", tx_data_vld_a); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_cnt++; if (tx_data_vld_a !== 1'b0) begin mis_cnt++; $display("FAIL rstmid_vld: got %b exp 0", tx_data_vld_a); end
    cmp_cnt++; if (tx_data_a !== 8'h00) begin mis_cnt++; $display("FAIL rstmid_data: got %h exp 00", tx_data_a); end
    cmp_cnt++; if (rd_inc_a !== 1'b0) begin mis_cnt++; $display("FAIL rstmid_rd_inc: got %b exp 0", rd_inc_a); end
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL rstmid_active: got %b exp 0", active_a); end
    tick();
    cmp_cnt++; if (active_a !== 1'b0) begin mis_cnt++; $display("FAIL rstmid_idle: got %b exp 0", active_a); end
    tx_en_a = 1'b0;
  endtask

  task automatic test_busy_tmo_coincide();
    do_reset();
    tx_busy_a = 1'b0;
    push_a(8'h99);
    tx_en_a = 1'b1;
    tick();
    tx_en_a = 1'b0;
    repeat (63) tick();
    cmp_cnt++; if (tx_data_vld_a !== 1'b1) begin mis_cnt++; $display("FAIL coinc_vld_64: got %b exp 1", tx_data_vld_a); end
    tx_busy_a = 1'b1;
    tick();
    cmp_cnt++; if (tx_data_vld_a !== 1'b0) begin mis_cnt++; $display("FAIL coinc_vld_drop: got %b exp 0", tx_data_vld_a); end
    cmp_cnt++; if (tmo_err_a !== 1'b0) begin mis_cnt++; $display("FAIL coinc_tmo_err: got %b exp 0", tmo_err_a); end
    tx_busy_a = 1'b0;
    tick();
    cmp_cnt++; if (sent_cnt_a !== 16'd1) begin mis_cnt++; $display("FAIL coinc_sent: got %0d exp 1", sent_cnt_a); end
    repeat (4) tick();
  endtask

  task automatic test_counter_wrap();
    int p0, n;
    logic [7:0] e;
    do_reset();
    p0 = rd_b;
    for (int i = 0; i < 17; i++) push_b(8'(8'h40 + i));
    tx_en_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (!tx_data_vld_b && n < 20) begin tick(); n++; end
      e = 8'(8'h40 + i);
      cmp_cnt++; if (n !== ((i == 0) ? 1 : 2)) begin mis_cnt++; $display("FAIL wrap_b2b_latency[%0d]: got %0d exp %0d", i, n, (i == 0) ? 1 : 2); end
      cmp_cnt++; if (rd_inc_b !== 1'b1) begin mis_cnt++; $display("FAIL wrap_pop[%0d]: got %b exp 1", i, rd_inc_b); end
      cmp_cnt++; if (tx_data_b !== e) begin mis_cnt++; $display("FAIL wrap_data[%0d]: got %h exp %h", i, tx_data_b, e); end
      tx_busy_b = 1'b1;
      tick();
      tx_busy_b = 1'b0;
    end
    repeat (2) tick();
    tx_en_b = 1'b0;
    cmp_cnt++; if (sent_cnt_b !== 4'd1) begin mis_cnt++; $display("FAIL wrap_sent: got %0d exp 1", sent_cnt_b); end
    cmp_cnt++; if (rd_b - p0 !== 17) begin mis_cnt++; $display("FAIL wrap_pops: got %0d exp 17", rd_b - p0); end
    cmp_cnt++; if (active_b !== 1'b0) begin mis_cnt++; $display("FAIL wrap_idle: got %b exp 0", active_b); end
  endtask

  task automatic test_no_empty_pop();
    cmp_cnt++; if (bad_pop_a !== 1'b0) begin mis_cnt++; $display("FAIL empty_pop_a: got %b exp 0", bad_pop_a); end
    cmp_cnt++; if (bad_pop_b !== 1'b0) begin mis_cnt++; $display("FAIL empty_pop_b: got %b exp 0", bad_pop_b); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_timeout();
    test_enable_gating();
    test_reset_mid_launch();
    test_busy_tmo_coincide();
    test_counter_wrap();
    test_no_empty_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
